// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace frames into a 30-bit word and count; dct_valid pulses the cycle after a full or flushed word.
// Never stalls; an end-of-test drain emits any partial word before test_ending and test_has_ended are raised.
module nios2_oci_dct_packer #(
  parameter int FRAME_W    = 2,
  parameter int NUM_FRAMES = 15,
  parameter int CNT_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          trace_en,
  input  logic                          frame_valid,
  input  logic [FRAME_W-1:0]            frame_data,
  input  logic                          flush,
  input  logic                          stop_req,
  output logic [FRAME_W*NUM_FRAMES-1:0] dct_buffer,
  output logic [CNT_W-1:0]              dct_count,
  output logic                          dct_valid,
  output logic                          test_ending,
  output logic                          test_has_ended
);

  localparam int                WORD_W   = FRAME_W * NUM_FRAMES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_FRAMES);

  typedef enum logic [1:0] {RUN, DRAIN, ENDING, ENDED} state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   dct_buffer_q;
  logic [CNT_W-1:0]    dct_count_q;
  logic                dct_valid_q;
  logic                test_ending_q;
  logic                test_has_ended_q;
  logic                accept;
  logic                emit;

  always_comb begin
    accept = frame_valid && trace_en && (state_q == RUN);
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (accept) begin
      acc_d = {acc_q[WORD_W-FRAME_W-1:0], frame_data};
      cnt_d = cnt_q + 1'b1;
    end
    // The same-cycle frame counts toward both the full check and the flush check.
    emit = ((state_q == RUN) && ((cnt_d == FULL_CNT) || (flush && (cnt_d != '0)))) ||
           ((state_q == DRAIN) && (cnt_q != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= RUN;
      acc_q            <= '0;
      cnt_q            <= '0;
      dct_buffer_q     <= '0;
      dct_count_q      <= '0;
      dct_valid_q      <= 1'b0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      dct_valid_q <= emit;
      if (emit) begin
        dct_buffer_q <= acc_d;
        dct_count_q  <= cnt_d;
        acc_q        <= '0;
        cnt_q        <= '0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
      case (state_q)
        RUN:    if (stop_req) state_q <= DRAIN;
        DRAIN:  state_q <= ENDING;
        ENDING: begin
          test_ending_q <= 1'b1;
          state_q       <= ENDED;
        end
        ENDED:  test_has_ended_q <= 1'b1;
        default: state_q <= RUN;
      endcase
    end
  end

  assign dct_buffer     = dct_buffer_q;
  assign dct_count      = dct_count_q;
  assign dct_valid      = dct_valid_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Bench for nios2_oci_dct_packer: queue-of-frames reference model feeding a per-cycle expectation scoreboard.
module tb_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trace_en = 1'b0;
  logic        frame_valid = 1'b0;
  logic [1:0]  frame_data = 2'b00;
  logic        flush = 1'b0;
  logic        stop_req = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        test_ending;
  logic        test_has_ended;

  nios2_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .trace_en(trace_en), .frame_valid(frame_valid),
    .frame_data(frame_data), .flush(flush), .stop_req(stop_req),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        emit;
    bit [29:0] wd;
    bit [3:0]  cnt;
    bit        ending;
    bit        ended;
  } exp_t;

  exp_t      expq[$];
  int        fq[$];
  int        since_stop = -1;
  bit [29:0] last_w = '0;
  bit [3:0]  last_c = '0;
  int        tests = 0;
  int        fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference: frames held in a queue; a word is the frames read as base-4 digits, oldest most significant.
  task automatic cyc(input bit fv, input bit en, input bit [1:0] d, input bit fl, input bit st);
    exp_t      e;
    bit [29:0] w;
    @(negedge clk);
    frame_valid = fv; trace_en = en; frame_data = d; flush = fl; stop_req = st;
    e.emit = 1'b0;
    if (since_stop < 0) begin
      if (fv && en) fq.push_back(int'(d));
      if (fq.size() == 15 || (fl && fq.size() > 0)) e.emit = 1'b1;
      if (st) since_stop = 0;
    end else begin
      since_stop++;
      if (since_stop == 1 && fq.size() > 0) e.emit = 1'b1;
    end
    if (e.emit) begin
      w = '0;
      foreach (fq[i]) w = w * 4 + 30'(fq[i]);
      last_w = w;
      last_c = 4'(fq.size());
      fq.delete();
    end
    e.wd     = last_w;
    e.cnt    = last_c;
    e.ending = (since_stop >= 2);
    e.ended  = (since_stop >= 3);
    expq.push_back(e);
  endtask

  task automatic rst();
    @(negedge clk);
    reset_n = 1'b0;
    frame_valid = 1'b0; trace_en = 1'b0; flush = 1'b0; stop_req = 1'b0; frame_data = 2'b00;
    #1;
    chk("rst_buffer", 32'(dct_buffer), 0);
    chk("rst_count", 32'(dct_count), 0);
    chk("rst_valid", 32'(dct_valid), 0);
    chk("rst_ending", 32'(test_ending), 0);
    chk("rst_ended", 32'(test_has_ended), 0);
    fq.delete();
    expq.delete();
    since_stop = -1;
    last_w = '0;
    last_c = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (reset_n && expq.size() > 0) begin
      me = expq.pop_front();
      chk("dct_valid", 32'(dct_valid), 32'(me.emit));
      chk("dct_buffer", 32'(dct_buffer), 32'(me.wd));
      chk("dct_count", 32'(dct_count), 32'(me.cnt));
      chk("test_ending", 32'(test_ending), 32'(me.ending));
      chk("test_has_ended", 32'(test_has_ended), 32'(me.ended));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst();
    // 15 frames of 01 -> 0x15555555
    repeat (15) cyc(1, 1, 2'd1, 0, 0);
    cyc(0, 1, 2'd0, 0, 0);
    // 3,2,1 + flush -> 0x39, then empty flush
    cyc(1, 1, 2'd3, 0, 0);
    cyc(1, 1, 2'd2, 0, 0);
    cyc(1, 1, 2'd1, 0, 0);
    cyc(0, 1, 2'd0, 1, 0);
    cyc(0, 1, 2'd0, 1, 0);
    // 15th frame coincides with flush
    repeat (14) cyc(1, 1, 2'($urandom), 0, 0);
    cyc(1, 1, 2'd2, 1, 0);
    // trace_en low drops frames
    cyc(1, 0, 2'd2, 0, 0);
    cyc(1, 0, 2'd2, 0, 0);
    cyc(1, 1, 2'd1, 0, 0);
    cyc(0, 1, 2'd0, 1, 0);
    // random traffic while running
    repeat (400) cyc($urandom_range(3) != 0, $urandom_range(4) != 0, 2'($urandom),
                     $urandom_range(11) == 0, 0);
    cyc(0, 1, 2'd0, 1, 0);
    // drain: five 11 frames -> 0x3FF, then terminal state ignores everything
    repeat (5) cyc(1, 1, 2'd3, 0, 0);
    cyc(0, 1, 2'd0, 0, 1);
    repeat (20) cyc($urandom_range(1) != 0, 1, 2'($urandom), $urandom_range(1) != 0,
                    $urandom_range(1) != 0);
    // reset mid-word
    repeat (7) cyc(1, 1, 2'd3, 0, 0);
    rst();
    repeat (15) cyc(1, 1, 2'd2, 0, 0);
    cyc(0, 1, 2'd0, 0, 0);
    // random run ending in a stop with a frame in the stop cycle
    repeat (300) cyc($urandom_range(3) != 0, $urandom_range(4) != 0, 2'($urandom),
                     $urandom_range(15) == 0, 0);
    cyc(1, 1, 2'($urandom), 0, 1);
    repeat (6) cyc(1, 1, 2'($urandom), 1, 1);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
- Packs 2-bit debug compressed-trace (DCT) frames from the OCI trace path into a 30-bit word plus a frame count.
- Presents the word as dct_buffer/dct_count to the OCI test-bench stage directly downstream.
- Generates the test_ending and test_has_ended end-of-test indications that the same stage consumes.
- Sits between the CPU trace-frame source and the test-bench monitor.

Parameters:
FRAME_W, 2, bits per trace frame
NUM_FRAMES, 15, frames per packed word (FRAME_W*NUM_FRAMES = 30 = dct_buffer width)
CNT_W, 4, width of dct_count (must hold NUM_FRAMES)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
trace_en  in  1  frames accepted only while high
frame_valid  in  1  frame_data valid this cycle
frame_data  in  FRAME_W  trace frame code
flush  in  1  one-cycle request to emit a partial word
stop_req  in  1  one-cycle request to end test
dct_buffer  out  30  packed frames, oldest in the highest occupied bits
dct_count  out  CNT_W  number of valid frames in dct_buffer (1..15)
dct_valid  out  1  one-cycle pulse: dct_buffer/dct_count updated this cycle
test_ending  out  1  end-of-test drain complete, sticky
test_has_ended  out  1  asserted one cycle after test_ending, sticky

Behaviour:
- Reset, asynchronous: dct_buffer=0, dct_count=0, dct_valid=0, test_ending=0, test_has_ended=0, internal accumulator=0, internal count=0, state=RUN.
- Accept: a frame is taken when frame_valid && trace_en && state==RUN.
- Accumulate: acc <= {acc[27:0], frame_data}; cnt <= cnt+1.
- Full emit: when an accepted frame makes cnt reach NUM_FRAMES:
  - next edge: dct_buffer <= new acc, dct_count <= 15, dct_valid=1 for one cycle.
  - acc and cnt clear to 0 on the same edge.
  - Latency: frame in cycle N produces dct_valid in cycle N+1.
- Flush with cnt>0 (after including any same-cycle accepted frame): emit partial word on the next edge.
  - dct_buffer = acc right-aligned, unused upper bits 0.
  - dct_count = frames held; acc and cnt clear.
- Flush with cnt==0 and no same-cycle frame: no emit; dct_valid stays 0.
- Flush coinciding with a full emit: one emit only (count 15).
- Between emits: dct_buffer/dct_count hold their last emitted value; dct_valid=0.
- The count never wraps; at most one emit occurs per cycle.
- State machine:
  - RUN: stop_req -> DRAIN. A frame accepted in the stop_req cycle is still included.
  - DRAIN (1 cycle): frames are ignored. Performs an implicit flush (partial emit if cnt>0). -> ENDING.
  - ENDING: test_ending <= 1. -> ENDED.
  - ENDED: test_has_ended <= 1. Terminal; both flags sticky until reset_n.
- test_ending always rises at least one cycle after the final dct_valid pulse. The final word is therefore observed by the downstream stage before test_ending.
- stop_req outside RUN is ignored. flush outside RUN is ignored; DRAIN performs its own flush.
- trace_en low: frames dropped, partial acc retained, flush still honoured.
- reset_n asserted mid-word or mid-drain: everything returns to reset values immediately, with no emit. Operation resumes in RUN on the first edge after release.

Test Plan:
- After reset, 15 accepted frames of 2'b01 in consecutive cycles -> one dct_valid pulse in the cycle after the 15th frame; dct_buffer=30'h15555555, dct_count=15; acc empty afterwards.
- Frames 3,2,1 then flush -> dct_valid the next cycle; dct_buffer=30'h39, dct_count=3. A second flush with no frames produces no pulse.
- 14 frames, then frame 15 and flush in the same cycle -> exactly one pulse, dct_count=15.
- Frames 2,2 with trace_en=0, then frame 1 with trace_en=1, then flush -> dct_buffer=1, dct_count=1.
- 5 frames of 2'b11, then stop_req -> DRAIN emits dct_buffer=30'h3FF, dct_count=5. test_ending rises the following cycle and test_has_ended one cycle later; further frames, flushes and stop_reqs cause no emits and the flags stay 1.
- Assert reset_n low after 7 frames, then release -> all outputs 0. Then 15 frames -> a full word whose content contains none of the pre-reset frames.
